// File: rtl/da_lut_builder.sv
// -----------------------------------------------------------------------------
// da_lut_builder
//   Writer side of the distributed-arithmetic FIR lookup tables. Collects ORDER
//   signed coefficients over a valid/ready stream, then writes every partial-sum
//   entry of each of the PARTITION tables, one entry per clock.
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous reset, active-high
//   i_start       begin a new coefficient load (honoured only in IDLE)
//   i_coef_valid  coefficient beat valid
//   o_coef_ready  builder accepts a coefficient this cycle (LOAD state)
//   i_coef        signed coefficient, tap order 0..ORDER-1
//   o_we          LUT write strobe
//   o_part        partition being written
//   o_waddr       LUT entry address
//   o_wdata       LUT entry value (signed partial sum)
//   o_busy        high while LOAD, BUILD or DONE
//   o_done        one-cycle pulse after the final write
//   o_lut_valid   all tables hold the sums of the last complete load
// -----------------------------------------------------------------------------
module da_lut_builder #(
   parameter  int OPSIZE    = 12,
   parameter  int ORDER     = 6,
   parameter  int PARTITION = 2,
   localparam int K         = ORDER / PARTITION,
   localparam int CELLS     = 2 ** K,
   localparam int LUT_W     = OPSIZE + $clog2(K),
   localparam int PW        = (PARTITION > 1) ? $clog2(PARTITION) : 1,
   localparam int TW        = (ORDER > 1) ? $clog2(ORDER) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic              i_coef_valid,
   output logic              o_coef_ready,
   input  logic [OPSIZE-1:0] i_coef,
   output logic              o_we,
   output logic [PW-1:0]     o_part,
   output logic [K-1:0]      o_waddr,
   output logic [LUT_W-1:0]  o_wdata,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_lut_valid
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_BUILD,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic signed [OPSIZE-1:0] coef_q [ORDER];
   logic [TW-1:0]            tap_cnt;
   logic [K-1:0]             addr_cnt;
   logic [PW-1:0]            part_cnt;

   logic                     hs;
   logic                     last_tap;
   logic                     last_entry;
   logic signed [LUT_W-1:0]  part_sum [PARTITION];
   logic signed [LUT_W-1:0]  entry;

   assign o_coef_ready = (state == S_LOAD);
   assign o_busy       = (state != S_IDLE);
   assign hs           = (state == S_LOAD) && i_coef_valid;
   assign last_tap     = (tap_cnt == TW'(ORDER - 1));
   assign last_entry   = (part_cnt == PW'(PARTITION - 1)) && (addr_cnt == '1);

   // -------------------------------------------------------------------------
   // Partial sums: every partition gets its own adder chain over its K taps,
   // each tap gated by the matching address bit; the current partition's chain
   // output is the entry written this cycle.
   // -------------------------------------------------------------------------
   for (genvar p = 0; p < PARTITION; p++) begin : g_part
      for (genvar b = 0; b < K; b++) begin : g_bit
         logic signed [LUT_W-1:0] term;
         logic signed [LUT_W-1:0] prev;
         logic signed [LUT_W-1:0] acc;
         // Size cast of a signed operand sign-extends the coefficient.
         assign term = addr_cnt[b] ? LUT_W'(coef_q[p*K + b]) : '0;
         if (b == 0) begin : g_first
            assign prev = '0;
         end else begin : g_next
            assign prev = g_bit[b-1].acc;
         end
         assign acc = prev + term;
      end
      assign part_sum[p] = g_bit[K-1].acc;
   end

   assign entry = part_sum[part_cnt];

   // -------------------------------------------------------------------------
   // FSM
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // NOTE: next state defaults to the current state before the case, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (i_start)           state_nxt = S_LOAD;
         S_LOAD:  if (hs && last_tap)    state_nxt = S_BUILD;
         S_BUILD: if (last_entry)        state_nxt = S_DONE;
         S_DONE:                         state_nxt = S_IDLE;
         default:                        state_nxt = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Coefficient storage
   // NOTE: the coefficient array is deliberately not reset: every entry is
   // rewritten by a full load before any table is built from it, and leaving
   // it out of reset lets it map onto plain registers or distributed RAM.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (hs) coef_q[tap_cnt] <= i_coef;
   end

   // -------------------------------------------------------------------------
   // Counters and registered write port
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         tap_cnt     <= '0;
         addr_cnt    <= '0;
         part_cnt    <= '0;
         o_we        <= 1'b0;
         o_part      <= '0;
         o_waddr     <= '0;
         o_wdata     <= '0;
         o_done      <= 1'b0;
         o_lut_valid <= 1'b0;
      end else begin
         o_we   <= 1'b0;
         o_done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (i_start) begin
                  o_lut_valid <= 1'b0;
                  tap_cnt     <= '0;
                  addr_cnt    <= '0;
                  part_cnt    <= '0;
               end
            end
            S_LOAD: begin
               if (hs) tap_cnt <= last_tap ? '0 : tap_cnt + TW'(1);
            end
            S_BUILD: begin
               o_we     <= 1'b1;
               o_part   <= part_cnt;
               o_waddr  <= addr_cnt;
               o_wdata  <= entry;
               // Address wraps naturally at CELLS-1; partition steps with it.
               addr_cnt <= addr_cnt + K'(1);
               if (addr_cnt == '1)
                  part_cnt <= last_entry ? '0 : part_cnt + PW'(1);
            end
            S_DONE: begin
               o_done      <= 1'b1;
               o_lut_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_da_lut_builder.sv
// -----------------------------------------------------------------------------
// tb_da_lut_builder
//   Directed bench for da_lut_builder: loads coefficient sets, captures every
//   LUT write and compares tables, write timing and control outputs against
//   hand-computed values and a small partial-sum model.
// -----------------------------------------------------------------------------
module tb_da_lut_builder;

   localparam int OPSIZE    = 12;
   localparam int ORDER     = 6;
   localparam int PARTITION = 2;
   localparam int K         = 3;
   localparam int CELLS     = 8;
   localparam int LUT_W     = 14;
   localparam int PW        = 1;
   localparam int N_WR      = PARTITION * CELLS;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_start;
   logic              i_coef_valid;
   logic              o_coef_ready;
   logic [OPSIZE-1:0] i_coef;
   logic              o_we;
   logic [PW-1:0]     o_part;
   logic [K-1:0]      o_waddr;
   logic [LUT_W-1:0]  o_wdata;
   logic              o_busy;
   logic              o_done;
   logic              o_lut_valid;

   da_lut_builder #(
      .OPSIZE    (OPSIZE),
      .ORDER     (ORDER),
      .PARTITION (PARTITION)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_start      (i_start),
      .i_coef_valid (i_coef_valid),
      .o_coef_ready (o_coef_ready),
      .i_coef       (i_coef),
      .o_we         (o_we),
      .o_part       (o_part),
      .o_waddr      (o_waddr),
      .o_wdata      (o_wdata),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_lut_valid  (o_lut_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------------------------------------------------------- capture
   int  lut [PARTITION][CELLS];
   int  wr_cnt;
   int  we_rises;
   int  first_we_cyc;
   int  last_we_cyc;
   bit  we_prev = 1'b0;

   always @(negedge clk) begin
      if (o_we) begin
         if (wr_cnt == 0) first_we_cyc = cyc;
         last_we_cyc = cyc;
         lut[int'(o_part)][int'(o_waddr)] = int'($signed(o_wdata));
         wr_cnt++;
         if (!we_prev) we_rises++;
      end
      we_prev = o_we;
   end

   task automatic clear_stats();
      wr_cnt       = 0;
      we_rises     = 0;
      first_we_cyc = -1;
      last_we_cyc  = -1;
      for (int p = 0; p < PARTITION; p++)
         for (int a = 0; a < CELLS; a++)
            lut[p][a] = 99999;
   endtask

   // Reference partial sum for partition p, address a.
   function automatic int model(input int c[ORDER], input int p, input int a);
      int s = 0;
      for (int b = 0; b < K; b++)
         if (((a >> b) & 1) == 1) s += c[p*K + b];
      return s;
   endfunction

   // Caller sits at a negedge; returns at the negedge after the last handshake.
   task automatic load_coefs(input int c[ORDER], input bit gaps, output int e_last);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      check("load_ready", int'(o_coef_ready), 1);
      check("load_lut_valid_clr", int'(o_lut_valid), 0);
      e_last = 0;
      for (int n = 0; n < ORDER; n++) begin
         if (gaps) begin
            i_coef_valid = 1'b0;
            i_coef       = 12'h5A5;
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
         i_coef_valid = 1'b1;
         i_coef       = OPSIZE'(c[n]);
         e_last       = cyc + 1;
         @(negedge clk);
      end
      i_coef_valid = 1'b0;
      check("no_we_during_load", wr_cnt, 0);
   endtask

   // Returns at the negedge where o_done is seen high.
   task automatic wait_done(input int e_last, input string tag);
      int n = 0;
      while (!o_done && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!o_done) begin
         check({tag, "_done_timeout"}, 0, 1);
      end else begin
         check({tag, "_done_cycle"}, cyc, e_last + N_WR + 1);
         check({tag, "_lut_valid"}, int'(o_lut_valid), 1);
         check({tag, "_we_low_at_done"}, int'(o_we), 0);
      end
   endtask

   task automatic verify_build(input int c[ORDER], input int e_last, input string tag);
      check({tag, "_wr_cnt"}, wr_cnt, N_WR);
      check({tag, "_we_contiguous"}, we_rises, 1);
      check({tag, "_first_we"}, first_we_cyc, e_last + 1);
      check({tag, "_last_we"}, last_we_cyc, e_last + N_WR);
      for (int p = 0; p < PARTITION; p++)
         for (int a = 0; a < CELLS; a++)
            check($sformatf("%s_p%0d_a%0d", tag, p, a), lut[p][a], model(c, p, a));
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      int c1  [ORDER] = '{1, 2, 4, 8, 16, 32};
      int c2  [ORDER] = '{-2048, -2048, -2048, -2048, -2048, -2048};
      int c3  [ORDER] = '{3, -5, 7, 100, -2048, 2047};
      int c4  [ORDER] = '{-1, 9, -300, 511, 12, -7};
      int c6a [ORDER] = '{1, 2, 3, 4, 5, 6};
      int c6b [ORDER] = '{6, 5, 4, 3, 2, 1};
      int e;

      rst          = 1'b1;
      i_start      = 1'b0;
      i_coef_valid = 1'b0;
      i_coef       = '0;
      clear_stats();
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_ready", int'(o_coef_ready), 0);
      check("rst_we", int'(o_we), 0);
      check("rst_busy", int'(o_busy), 0);
      check("rst_done", int'(o_done), 0);
      check("rst_lut_valid", int'(o_lut_valid), 0);
      check("rst_part", int'(o_part), 0);
      check("rst_waddr", int'(o_waddr), 0);
      check("rst_wdata", int'(o_wdata), 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_busy", int'(o_busy), 0);

      // 1: powers of two
      clear_stats();
      load_coefs(c1, 1'b0, e);
      check("t1_busy_in_build", int'(o_busy), 1);
      wait_done(e, "t1");
      verify_build(c1, e, "t1");
      check("t1_p0_a5", lut[0][5], 5);
      check("t1_p0_a7", lut[0][7], 7);
      check("t1_p1_a3", lut[1][3], 24);
      check("t1_p1_a7", lut[1][7], 56);
      check("t1_p0_a0", lut[0][0], 0);
      check("t1_p1_a0", lut[1][0], 0);
      @(negedge clk);
      check("t1_done_one_cycle", int'(o_done), 0);
      check("t1_lut_valid_held", int'(o_lut_valid), 1);
      check("t1_idle_busy", int'(o_busy), 0);
      check("t1_wdata_held", int'($signed(o_wdata)), 56);

      // 2: most negative coefficients, no overflow
      clear_stats();
      load_coefs(c2, 1'b0, e);
      wait_done(e, "t2");
      verify_build(c2, e, "t2");
      check("t2_p0_a7", lut[0][7], -6144);
      check("t2_p0_a7_raw", lut[0][7] & 'h3FFF, 'h2800);
      check("t2_p1_a1", lut[1][1], -2048);
      check("t2_p1_a1_raw", lut[1][1] & 'h3FFF, 'h3800);
      @(negedge clk);

      // 3: gaps in valid during LOAD
      clear_stats();
      load_coefs(c1, 1'b1, e);
      wait_done(e, "t3");
      verify_build(c1, e, "t3");
      @(negedge clk);

      // 4: reset in the 5th BUILD cycle, then a fresh load
      clear_stats();
      load_coefs(c3, 1'b0, e);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t4_we_after_rst", int'(o_we), 0);
      check("t4_busy_after_rst", int'(o_busy), 0);
      check("t4_done_after_rst", int'(o_done), 0);
      check("t4_lut_valid_after_rst", int'(o_lut_valid), 0);
      check("t4_writes_before_rst", wr_cnt, 4);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (o_done || o_we || o_busy || o_lut_valid) begin
            check("t4_quiet_after_abort", 0, 1);
            break;
         end
      end
      check("t4_writes_after_abort", wr_cnt, 4);
      clear_stats();
      load_coefs(c4, 1'b0, e);
      wait_done(e, "t4");
      verify_build(c4, e, "t4");
      @(negedge clk);

      // 5: valid in IDLE and start during BUILD are ignored
      i_coef_valid = 1'b1;
      i_coef       = 12'h7FF;
      repeat (3) @(negedge clk);
      check("t5_ready_idle", int'(o_coef_ready), 0);
      check("t5_busy_idle", int'(o_busy), 0);
      i_coef_valid = 1'b0;
      clear_stats();
      load_coefs(c3, 1'b0, e);
      repeat (3) @(negedge clk);
      i_start = 1'b1;
      check("t5_ready_build", int'(o_coef_ready), 0);
      check("t5_busy_build", int'(o_busy), 1);
      @(negedge clk);
      i_start = 1'b0;
      wait_done(e, "t5");
      verify_build(c3, e, "t5");
      repeat (2) @(negedge clk);
      check("t5_back_idle_busy", int'(o_busy), 0);
      check("t5_back_idle_ready", int'(o_coef_ready), 0);

      // 6: back-to-back builds, second start issued in the o_done cycle
      clear_stats();
      load_coefs(c6a, 1'b0, e);
      wait_done(e, "t6a");
      verify_build(c6a, e, "t6a");
      check("t6a_p1_a7", lut[1][7], 15);
      clear_stats();
      load_coefs(c6b, 1'b0, e);
      wait_done(e, "t6b");
      verify_build(c6b, e, "t6b");
      check("t6b_p1_a7", lut[1][7], 6);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "global timeout");
   end

endmodule
